// File: rtl/adder_tree_sched.sv
// adder_tree_sched: issues operand beats into the pipelined adder tree, tracks
// each beat through the tree latency, accumulates CH_NUM tree results per
// output pixel (starting from a bias, with saturation) and queues finished
// pixels in a small output FIFO. Credits stop new pixel groups from starting
// when the FIFO could not absorb their result.
module adder_tree_sched #(
    parameter int dwidth     = 16,
    parameter int CH_NUM     = 6,
    parameter int TREE_LAT   = 3,
    parameter int FIFO_DEPTH = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    output logic              tree_en,
    input  logic [dwidth-1:0] tree_dout,
    input  logic [dwidth-1:0] bias,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [dwidth-1:0] out_data,
    output logic              sat_flag,
    output logic              busy
);

    localparam int BW = (CH_NUM > 1) ? $clog2(CH_NUM) : 1;
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = AW + 1;

    localparam logic [BW-1:0]     LAST_BEAT = BW'(CH_NUM - 1);
    localparam logic [CW-1:0]     DEPTH_C   = CW'(FIFO_DEPTH);
    localparam logic [dwidth-1:0] SAT_MAX   = {1'b0, {(dwidth-1){1'b1}}};
    localparam logic [dwidth-1:0] SAT_MIN   = {1'b1, {(dwidth-1){1'b0}}};

    // Signed add of two dwidth values in dwidth+1 bits, clamped to the
    // dwidth range. Returns {clamped, value}.
    function automatic logic [dwidth:0] sat_add(
        input logic [dwidth-1:0] a,
        input logic [dwidth-1:0] b
    );
        logic [dwidth:0] sum;
        logic [dwidth:0] res;
        sum = {a[dwidth-1], a} + {b[dwidth-1], b};
        if (sum[dwidth] != sum[dwidth-1]) begin
            if (sum[dwidth]) begin
                res = {1'b1, SAT_MIN};
            end else begin
                res = {1'b1, SAT_MAX};
            end
        end else begin
            res = {1'b0, sum[dwidth-1:0]};
        end
        return res;
    endfunction

    // State
    logic [BW-1:0]       beat_cnt_r;
    logic [CW-1:0]       open_groups_r;
    logic [CW-1:0]       fifo_count_r;
    logic [AW-1:0]       wr_ptr_r;
    logic [AW-1:0]       rd_ptr_r;
    logic [dwidth-1:0]   fifo_mem_r [FIFO_DEPTH];
    logic [dwidth-1:0]   acc_r;
    logic                sat_flag_r;
    logic [TREE_LAT-1:0] vld_pipe_r;
    logic [TREE_LAT-1:0] first_pipe_r;
    logic [TREE_LAT-1:0] last_pipe_r;

    // Combinational
    logic [CW-1:0]     reserved_s;
    logic              in_ready_s;
    logic              accept_s;
    logic              first_in_s;
    logic              last_in_s;
    logic              al_vld_s;
    logic              al_first_s;
    logic              al_last_s;
    logic [dwidth-1:0] src_s;
    logic [dwidth:0]   sat_res_s;
    logic              push_s;
    logic              pop_s;
    logic              out_valid_s;

    assign reserved_s  = fifo_count_r + open_groups_r;
    assign first_in_s  = (beat_cnt_r == '0);
    assign last_in_s   = (beat_cnt_r == LAST_BEAT);
    // A group in progress (beat_cnt != 0) is never held back by credits.
    assign in_ready_s  = !rst && !(first_in_s && (reserved_s == DEPTH_C));
    assign accept_s    = in_valid && in_ready_s;

    assign al_vld_s    = vld_pipe_r[TREE_LAT-1];
    assign al_first_s  = first_pipe_r[TREE_LAT-1];
    assign al_last_s   = last_pipe_r[TREE_LAT-1];

    assign src_s       = al_first_s ? bias : acc_r;
    assign sat_res_s   = sat_add(src_s, tree_dout);

    assign out_valid_s = (fifo_count_r != '0);
    assign push_s      = al_vld_s && al_last_s;
    assign pop_s       = out_valid_s && out_ready;

    assign in_ready    = in_ready_s;
    assign tree_en     = accept_s;
    assign out_valid   = out_valid_s;
    assign out_data    = fifo_mem_r[rd_ptr_r];
    assign sat_flag    = sat_flag_r;
    assign busy        = (|vld_pipe_r) || (beat_cnt_r != '0) ||
                         (open_groups_r != '0) || (fifo_count_r != '0);

    // Beat counter: position of the next accepted beat within its group.
    always_ff @(posedge clk) begin
        if (rst) begin
            beat_cnt_r <= '0;
        end else if (accept_s) begin
            if (last_in_s) begin
                beat_cnt_r <= '0;
            end else begin
                beat_cnt_r <= beat_cnt_r + BW'(1);
            end
        end
    end

    // Valid/tag pipeline aligned with the tree latency.
    always_ff @(posedge clk) begin
        if (rst) begin
            vld_pipe_r   <= '0;
            first_pipe_r <= '0;
            last_pipe_r  <= '0;
        end else begin
            vld_pipe_r[0]   <= accept_s;
            first_pipe_r[0] <= accept_s && first_in_s;
            last_pipe_r[0]  <= accept_s && last_in_s;
            for (int i = 1; i < TREE_LAT; i++) begin
                vld_pipe_r[i]   <= vld_pipe_r[i-1];
                first_pipe_r[i] <= first_pipe_r[i-1];
                last_pipe_r[i]  <= last_pipe_r[i-1];
            end
        end
    end

    // Open-group credits: taken when a group starts, returned when its result lands in the FIFO.
    always_ff @(posedge clk) begin
        if (rst) begin
            open_groups_r <= '0;
        end else begin
            case ({accept_s && first_in_s, push_s})
                2'b10:   open_groups_r <= open_groups_r + CW'(1);
                2'b01:   open_groups_r <= open_groups_r - CW'(1);
                default: open_groups_r <= open_groups_r;
            endcase
        end
    end

    // Accumulator and sticky saturation flag, updated on every aligned valid beat.
    always_ff @(posedge clk) begin
        if (rst) begin
            acc_r      <= '0;
            sat_flag_r <= 1'b0;
        end else if (al_vld_s) begin
            acc_r      <= sat_res_s[dwidth-1:0];
            sat_flag_r <= sat_flag_r || sat_res_s[dwidth];
        end
    end

    // Output FIFO storage and write pointer; the saturated sum itself is pushed on the last beat.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_r <= '0;
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                fifo_mem_r[i] <= '0;
            end
        end else if (push_s) begin
            fifo_mem_r[wr_ptr_r] <= sat_res_s[dwidth-1:0];
            wr_ptr_r             <= wr_ptr_r + AW'(1);
        end
    end

    // FIFO read pointer and occupancy; push and pop together leave the count unchanged.
    always_ff @(posedge clk) begin
        if (rst) begin
            rd_ptr_r     <= '0;
            fifo_count_r <= '0;
        end else begin
            if (pop_s) begin
                rd_ptr_r <= rd_ptr_r + AW'(1);
            end
            case ({push_s, pop_s})
                2'b10:   fifo_count_r <= fifo_count_r + CW'(1);
                2'b01:   fifo_count_r <= fifo_count_r - CW'(1);
                default: fifo_count_r <= fifo_count_r;
            endcase
        end
    end

endmodule

// File: tb/tb_adder_tree_sched.sv
// Directed testbench for adder_tree_sched. Contains a 3-stage model of the
// adder tree that returns the operand sum chosen by the bench for each beat.
module tb_adder_tree_sched;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic        tree_en;
    logic [15:0] tree_dout;
    logic [15:0] bias;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] out_data;
    logic        sat_flag;
    logic        busy;

    int n_checks = 0;
    int n_fail   = 0;

    // Tree model and bookkeeping
    int          acc_beats = 0;
    int          beat_base = 0;
    int          val_base  = 0;
    int          val_step  = 0;
    logic [15:0] beat_val;
    logic [15:0] t1 = 16'h0000, t2 = 16'h0000, t3 = 16'h0000;
    int          cyc = 0;
    int          last_acc_cyc = 0;
    int          rise_cyc = 0;
    logic        ov_prev = 1'b0;
    int          bad_en = 0;
    logic [15:0] got_q[$];
    logic [15:0] exp_q[$];

    adder_tree_sched #(
        .dwidth(16), .CH_NUM(6), .TREE_LAT(3), .FIFO_DEPTH(4)
    ) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .tree_en(tree_en), .tree_dout(tree_dout), .bias(bias),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .sat_flag(sat_flag), .busy(busy)
    );

    always #5 clk = ~clk;

    // Per-beat tree sum: base value plus step per completed group in this scenario.
    assign beat_val  = 16'(val_base + val_step * ((acc_beats - beat_base) / 6));
    assign tree_dout = t3;

    // Tree model: zero operands when tree_en is low, three register stages.
    always @(posedge clk) begin
        t1  <= tree_en ? beat_val : 16'h0000;
        t2  <= t1;
        t3  <= t2;
        cyc <= cyc + 1;
        if (tree_en) acc_beats <= acc_beats + 1;
    end

    // Monitor on the inactive edge: output capture, latency marks, tree_en sanity.
    always @(negedge clk) begin
        if (out_valid && out_ready) got_q.push_back(out_data);
        if (tree_en) last_acc_cyc <= cyc;
        if (out_valid && !ov_prev) rise_cyc <= cyc;
        ov_prev <= out_valid;
        if (tree_en !== (in_valid && in_ready)) bad_en <= bad_en + 1;
    end

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Offer beats until n are accepted; reports cycles spent.
    task automatic send_beats(input int n, input bit bubbles, output int used);
        int got;
        got  = 0;
        used = 0;
        while (got < n && used < 300) begin
            in_valid = bubbles ? 1'($urandom_range(0, 1)) : 1'b1;
            @(negedge clk);
            if (in_valid && in_ready) got++;
            @(posedge clk);
            #1;
            used++;
        end
        in_valid = 1'b0;
        check_val("beats_sent", got, n);
    endtask

    // Wait (bounded) for the expected outputs, then compare them in order.
    task automatic expect_outs(input string tag);
        int k;
        k = 0;
        while (got_q.size() < exp_q.size() && k < 200) begin
            tick(1);
            k++;
        end
        tick(2);
        check_val({tag, "_count"}, got_q.size(), exp_q.size());
        for (int i = 0; i < exp_q.size(); i++) begin
            check_val({tag, "_data"}, (i < got_q.size()) ? got_q[i] : 16'hxxxx, exp_q[i]);
        end
        got_q.delete();
        exp_q.delete();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int used;
        rst       = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        bias      = 16'h0000;

        // Reset state
        tick(2);
        @(negedge clk);
        check_val("rst_in_ready", in_ready, 1'b0);
        check_val("rst_out_valid", out_valid, 1'b0);
        check_val("rst_out_data", out_data, 16'h0000);
        check_val("rst_sat_flag", sat_flag, 1'b0);
        check_val("rst_busy", busy, 1'b0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        check_val("post_rst_in_ready", in_ready, 1'b1);
        tick(1);

        // 1. Single pixel and latency
        bias = 16'h0800; val_base = 16'h0100; val_step = 0; beat_base = acc_beats;
        got_q.delete();
        send_beats(6, 1'b0, used);
        exp_q.push_back(16'h0E00);
        expect_outs("s1");
        check_val("s1_latency", rise_cyc - last_acc_cyc, 4);
        check_val("s1_sat_flag", sat_flag, 1'b0);
        check_val("s1_idle", busy, 1'b0);

        // 2. Back-to-back groups
        bias = 16'h0000; val_base = 16'h0010; val_step = 16'h0010; beat_base = acc_beats;
        send_beats(18, 1'b0, used);
        check_val("s2_no_stall", used, 18);
        exp_q.push_back(16'h0060); exp_q.push_back(16'h00C0); exp_q.push_back(16'h0120);
        expect_outs("s2");

        // 3. Backpressure and credits
        beat_base = acc_beats;
        out_ready = 1'b0;
        in_valid  = 1'b1;
        tick(40);
        check_val("s3_beats_4grp", acc_beats - beat_base, 24);
        check_val("s3_in_ready_blk", in_ready, 1'b0);
        check_val("s3_head_valid", out_valid, 1'b1);
        check_val("s3_head_data", out_data, 16'h0060);
        tick(3);
        check_val("s3_head_hold", out_data, 16'h0060);
        check_val("s3_busy", busy, 1'b1);
        out_ready = 1'b1;
        tick(1);
        out_ready = 1'b0;
        tick(20);
        check_val("s3_beats_5grp", acc_beats - beat_base, 30);
        check_val("s3_in_ready_blk2", in_ready, 1'b0);
        in_valid  = 1'b0;
        out_ready = 1'b1;
        exp_q.push_back(16'h0060); exp_q.push_back(16'h00C0); exp_q.push_back(16'h0120);
        exp_q.push_back(16'h0180); exp_q.push_back(16'h01E0);
        expect_outs("s3");

        // 4. Saturation, positive then negative
        bias = 16'h7000; val_base = 16'h1000; val_step = 16'hE000; beat_base = acc_beats;
        send_beats(6, 1'b0, used);
        exp_q.push_back(16'h7FFF);
        expect_outs("s4_pos");
        check_val("s4_sat_set", sat_flag, 1'b1);
        bias = 16'h8000;
        send_beats(6, 1'b0, used);
        exp_q.push_back(16'h8000);
        expect_outs("s4_neg");
        check_val("s4_sat_sticky", sat_flag, 1'b1);

        // 5. Bubbles
        bias = 16'h0800; val_base = 16'h0100; val_step = 0; beat_base = acc_beats;
        send_beats(6, 1'b1, used);
        exp_q.push_back(16'h0E00);
        expect_outs("s5");
        check_val("s5_en_pulses", acc_beats - beat_base, 6);

        // 6. Reset mid-group
        beat_base = acc_beats;
        send_beats(3, 1'b0, used);
        rst = 1'b1;
        @(negedge clk);
        check_val("s6_rst_in_ready", in_ready, 1'b0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        check_val("s6_busy", busy, 1'b0);
        check_val("s6_out_valid", out_valid, 1'b0);
        check_val("s6_sat_clr", sat_flag, 1'b0);
        tick(10);
        check_val("s6_no_output", got_q.size(), 0);
        beat_base = acc_beats;
        send_beats(6, 1'b0, used);
        exp_q.push_back(16'h0E00);
        expect_outs("s6");

        check_val("tree_en_match", bad_en, 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
